mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//   Iterative MIPS HI/LO multiply/divide unit. Sits directly downstream of the register file.
//   - Operands come from the register file read ports (rs -> read_data_1, rt -> read_data_2).
//   - Executes MULT, MULTU, DIV and DIVU, and holds the architectural HI/LO registers.
//   - Control stalls MFHI/MFLO while busy is high; results are read back through hi/lo into the writeback mux.
// PARAMETERS
//   XLEN  32  operand width; hi and lo are XLEN bits each; XLEN must be even and >= 8
// PORTS
//   clk       in   1     rising-edge clock
//   rst       in   1     synchronous, active-high reset
//   start     in   1     launch operation op on rs_data/rt_data; sampled only in IDLE
//   op        in   2     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data   in   XLEN  multiplicand / dividend
//   rt_data   in   XLEN  multiplier / divisor
//   mthi      in   1     write wdata into HI (MTHI)
//   mtlo      in   1     write wdata into LO (MTLO)
//   wdata     in   XLEN  MTHI/MTLO data
//   busy      out  1     operation in flight; control stalls MFHI/MFLO/MTHI/MTLO/start
//   done      out  1     one-cycle pulse; new hi/lo visible in this cycle
//   hi        out  XLEN  HI register
//   lo        out  XLEN  LO register
// BEHAVIOUR
//   Reset (rst=1 at a clk edge, in any state, including mid-operation):
//     state=IDLE, busy=0, done=0, hi=0, lo=0; any in-flight operation is discarded.
//   FSM:
//     IDLE -> RUN on start.
//     RUN  -> FIX after XLEN iteration cycles.
//     FIX  -> IDLE, writing hi/lo and pulsing done.
//   Latency:
//     - start is sampled at edge N; busy=1 in cycles N+1 .. N+XLEN+1 (XLEN+1 cycles).
//     - hi/lo update at edge N+XLEN+2; done=1 in the following cycle, with busy=0.
//   Operand capture: rs_data, rt_data and op are registered at the start edge; later changes are ignored.
//   Signed ops (MULT/DIV): iterate on absolute values; FIX applies signs.
//     - Product is negated when the operand signs differ.
//     - Quotient is negated when the operand signs differ; remainder takes the sign of the dividend.
//   MULT/MULTU: shift-add, one multiplier bit per cycle; {hi,lo} = full 2*XLEN-bit product.
//   DIV/DIVU: restoring divide, one quotient bit per cycle; lo = quotient, hi = remainder (truncating).
//   Boundary cases:
//     - Divide by zero: lo = all ones, hi = rs_data; full latency applies.
//     - Signed overflow (-2^(XLEN-1) / -1): lo = -2^(XLEN-1), hi = 0.
//     - start while busy: ignored; the running operation is unaffected.
//     - mthi/mtlo in IDLE: register written at the edge.
//     - mthi/mtlo while busy: ignored.
//     - mthi and mtlo together: both written.
//     - start together with mthi/mtlo in IDLE: start wins; the MT write is dropped.
//     - start in the done cycle (state IDLE): accepted normally (back-to-back issue).
// CONFIGURATION
//   FAST_MUL_EN defined:
//     - MULT/MULTU use a single-cycle combinational multiply.
//     - busy=1 for exactly 1 cycle (N+1); hi/lo update at edge N+2; done in cycle N+2.
//     - DIV/DIVU are unchanged.
//   FAST_MUL_EN undefined: all ops use the iterative XLEN+1-cycle path described above.
// TESTING
//   1. MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy for 33 cycles; done 1 cycle.
//   2. MULT rs=-7 (0xFFFFFFF9) rt=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6 (-42).
//   3. DIV rs=-7 rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//      DIVU rs=100 rt=7 -> lo=14, hi=2.
//   4. Divide edge cases:
//      - DIV rs=5 rt=0 -> lo=0xFFFFFFFF, hi=5.
//      - DIV rs=0x80000000 rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
//   5. Ignore rules during DIVU 100/7: assert mthi (wdata=0x1234) and start at cycle 5.
//      -> both ignored; final result hi=2, lo=14.
//      Then in IDLE: mtlo with wdata=0xABCD -> lo=0xABCD at the next edge.
//   6. rst=1 at cycle 10 of MULT 3*4 -> next cycle busy=0, done=0, hi=lo=0; no done pulse follows.
//      Rerun with FAST_MUL_EN: MULT 3*4 -> lo=12 with done 2 cycles after start.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: shift-add multiply, restoring divide.
// Define FAST_MUL_EN to replace the iterative multiply with a single-cycle one.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

    state_e            state_q, state_d;
    logic              is_div_q, is_div_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              done_q, done_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   rs_q, rs_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [2*XLEN-1:0] acc_q, acc_d;

    logic              rs_neg, rt_neg, div_ge;
    logic [XLEN-1:0]   abs_rs, abs_rt, div_rem, quo, rem;
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] mul_next, div_next, prod, prod_fix;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        rs_neg    = ~op[0] & rs_data[XLEN-1];
        rt_neg    = ~op[0] & rt_data[XLEN-1];
        abs_rs    = rs_neg ? -rs_data : rs_data;
        abs_rt    = rt_neg ? -rt_data : rt_data;

        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};

        div_trial = acc_q[2*XLEN-1:XLEN-1];
        div_ge    = div_trial >= {1'b0, opb_q};
        div_rem   = div_ge ? div_trial[XLEN-1:0] - opb_q : div_trial[XLEN-1:0];
        div_next  = {div_rem, acc_q[XLEN-2:0], div_ge};

`ifdef FAST_MUL_EN
        prod      = {{XLEN{1'b0}}, opb_q} * {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
`else
        prod      = acc_q;
`endif
        prod_fix  = neg_quo_q ? -prod : prod;
        quo       = neg_quo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem       = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end

    always_comb begin
        // NOTE: every *_d gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        is_div_d  = is_div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        rs_d      = rs_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_div_d  = op[1];
                    neg_quo_d = rs_neg ^ rt_neg;
                    neg_rem_d = rs_neg;
                    rs_d      = rs_data;
                    cnt_d     = '0;
                    opb_d     = op[1] ? abs_rt : abs_rs;
                    acc_d     = {{XLEN{1'b0}}, op[1] ? abs_rs : abs_rt};
`ifdef FAST_MUL_EN
                    state_d   = op[1] ? S_RUN : S_FIX;
`else
                    state_d   = S_RUN;
`endif
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (opb_q == '0) begin
                    // Divide by zero reports the untouched dividend in HI.
                    hi_d = rs_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // NOTE: datapath operand/accumulator flops carry no reset; they are loaded on start.
    always_ff @(posedge clk) begin
        is_div_q  <= is_div_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
        cnt_q     <= cnt_d;
        rs_q      <= rs_d;
        opb_q     <= opb_d;
        acc_q     <= acc_d;
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: arithmetic reference model plus directed vectors.
// Honours FAST_MUL_EN when the same define is given to the bench build.
module tb_mul_div_unit;
    localparam int XLEN = 32;
`ifdef FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;

    logic            clk = 1'b0;
    logic            rst, start, mthi, mtlo;
    logic [1:0]      op;
    logic [XLEN-1:0] rs_data, rt_data, wdata;
    logic            busy, done;
    logic [XLEN-1:0] hi, lo;

    mul_div_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result {hi, lo} straight from integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: return 64'(sa * sb);
            2'd1: return {32'b0, a} * {32'b0, b};
            2'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Cycle model: countdown of busy cycles, result lands when it expires.
    int          m_cnt = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else begin
            m_done <= (m_cnt == 1);
            if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_hi <= pend[63:32];
                    m_lo <= pend[31:0];
                end
            end else if (start) begin
                pend  <= ref_result(op, rs_data, rt_data);
                m_cnt <= op[1] ? DIV_LAT : MUL_LAT;
            end else begin
                if (mthi) m_hi <= wdata;
                if (mtlo) m_lo <= wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 64'(busy), 64'(m_cnt > 0));
            check("done", 64'(done), 64'(m_done));
            check("hi",   64'(hi),   64'(m_hi));
            check("lo",   64'(lo),   64'(m_lo));
        end
    end

    // Called at a negedge; returns at the negedge of the done cycle (or after a bound).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(negedge clk);
        start = 1'b0; op = ~o; rs_data = $urandom; rt_data = $urandom;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    vec_t vecs[$];
    int   lat, n_done;

    initial begin
        vecs.push_back('{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
        vecs.push_back('{2'd0, 32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFD6});
        vecs.push_back('{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back('{2'd3, 32'd100,       32'd7,         32'd2,         32'd14});
        vecs.push_back('{2'd2, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF});
        vecs.push_back('{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000});
        vecs.push_back('{2'd2, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF});
        vecs.push_back('{2'd3, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF});
        vecs.push_back('{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
        vecs.push_back('{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD});

        rst = 1'b1; start = 1'b0; op = 2'd0; mthi = 1'b0; mtlo = 1'b0;
        rs_data = '0; rt_data = '0; wdata = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i])
            check($sformatf("model_vec%0d", i), ref_result(vecs[i].op, vecs[i].a, vecs[i].b),
                  {vecs[i].hi, vecs[i].lo});

        // Directed vectors, each issued in the done cycle of the previous one.
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check($sformatf("lat_vec%0d", i), 64'(lat),
                  64'((vecs[i].op[1] ? DIV_LAT : MUL_LAT) + 1));
            check($sformatf("res_vec%0d", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
        end

        // DIVU 100/7 with MTHI and start attempted while busy.
        @(negedge clk);
        start = 1'b1; op = 2'd3; rs_data = 32'd100; rt_data = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; op = 2'd0; rs_data = 32'd3; rt_data = 32'd4;
        mthi = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("ignore_done_seen", 64'(done), 64'd1);
        check("ignore_result", {hi, lo}, {32'd2, 32'd14});

        @(negedge clk);
        mtlo = 1'b1; wdata = 32'hABCD;
        @(negedge clk);
        mtlo = 1'b0;
        check("mtlo_idle", {hi, lo}, {32'd2, 32'hABCD});

        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5555;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mthi_mtlo_both", {hi, lo}, {32'h5555, 32'h5555});

        // Start with MTHI in IDLE: start wins, HI keeps its old value while busy.
        start = 1'b1; op = 2'd1; rs_data = 32'd3; rt_data = 32'd4;
        mthi = 1'b1; wdata = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        check("start_beats_mt", 64'(hi), 64'h5555);
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("start_mt_result", {hi, lo}, {32'd0, 32'd12});

        // Reset in the middle of MULT 3*4.
        @(negedge clk);
        mthi = 1'b1; wdata = 32'h7777;
        @(negedge clk);
        mthi = 1'b0;
        start = 1'b1; op = 2'd0; rs_data = 32'd3; rt_data = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("midrst_no_done", 64'(n_done), 64'd0);

        run_op(2'd0, 32'd3, 32'd4, lat);
        check("mult_3x4_lat", 64'(lat), 64'(MUL_LAT + 1));
        check("mult_3x4_res", {hi, lo}, {32'd0, 32'd12});

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
